di2stream: RTL and testbench
============================

# di2stream

Host-to-image-stream playback block: the host writes frame pixels over the DI register bus into a ping-pong RAM, and the block replays each committed buffer as a standard image stream (`dvo`/`dtypeo`/`datao`) with frame/row framing and programmable row blanking. It sits on the DI bus in place of an imager and feeds downstream pipelines that consume the `dtypes.v` stream protocol. Two 16-bit pixels are packed per 32-bit DI word, low half first.

## Interface
- `ADDR_WIDTH`, 10: log2 of 32-bit words per buffer (two buffers).
- `DI_DATA_WIDTH`, 32: DI write data width; only bits [31:0] are used.
- `DIM_WIDTH`, 12: width of `num_cols` and `num_rows`.
- `BLANK_WIDTH`, 8: width of `row_blank`.

Ports:
- `clk` in 1: the only clock.
- `resetb` in 1: asynchronous, active-low reset.
- `enable` in 1: synchronous; low behaves as reset: FSMs idle, full flags cleared, outputs 0.
- `num_cols` in DIM_WIDTH: pixels per row; sampled at FRAME_START.
- `num_rows` in DIM_WIDTH: rows per frame; sampled at FRAME_START.
- `row_blank` in BLANK_WIDTH: idle cycles between rows; sampled at FRAME_START.
- `di_write_mode` in 1: high = host is filling a buffer; the falling edge commits it.
- `di_write` in 1: write strobe; one word per cycle when `di_write_rdy`=1.
- `di_reg_datai` in DI_DATA_WIDTH: write word {pixel n+1, pixel n}.
- `di_write_rdy` out 1: writes accepted.
- `dvo` out 1: stream data valid.
- `dtypeo` out `DTYPE_WIDTH`: stream type (`DTYPE_FRAME_START`, `DTYPE_ROW_START`, `DTYPE_PIXEL`, `DTYPE_ROW_END`, `DTYPE_FRAME_END`).
- `datao` out 16: pixel value; 0 on non-pixel beats.

## Operation
- Storage: `buffer[2][1<<ADDR_WIDTH]` of 32 bits, plus `full[1:0]`, write pointer `wbuf`, and read pointer `rbuf`.
- Write FSM WIDLE/WRITING:
  - WIDLE: `waddr`=0. When `di_write_mode`=1 and `full[wbuf]`=0, go to WRITING and set `di_write_rdy`=1.
  - WRITING: each `di_write` stores the word at `waddr` and increments `waddr`. Writes after the last address are dropped, and `waddr` saturates.
  - `di_write_mode`=0 in WRITING with at least one word written: set `full[wbuf]`, toggle `wbuf`, clear `di_write_rdy`, return to WIDLE.
  - `di_write_mode`=0 with zero words written: no commit.
- Stream FSM SIDLE → SFS → (SRS → SPIX → SRE → SBLANK)* → SFE → SIDLE.
  - SIDLE: when `full[rbuf]`=1, latch the config, clear the linear pixel index `p`, and go to SFS.
  - Each state emits one beat with `dvo`=1, except SBLANK (`dvo`=0 for `row_blank` cycles; skipped when `row_blank`=0 or after the last row).
  - SPIX lasts `num_cols` cycles, each emitting `datao` = `p` even ? `word[p>>1][15:0]` : `word[p>>1][31:16]`, then `p`++.
  - `p` runs continuously across rows, so odd `num_cols` is legal. Word addresses wrap modulo the buffer size.
  - SFE clears `full[rbuf]` and toggles `rbuf`.
- `num_cols`=0 or `num_rows`=0: emit FRAME_START, then FRAME_END, and release the buffer.
- Simultaneous commit (write side) and release (stream side) in one cycle: both take effect.
- Unwritten words replay their stale contents.

## Timing
- Reset: `di_write_rdy`=0, `dvo`=0, `dtypeo`=0, `datao`=0, `wbuf`=`rbuf`=0, `full`=0.
- All outputs are registered.
- `di_write_rdy` rises 1 cycle after `di_write_mode` is sampled high, if a buffer is free.
- Latency: the commit is sampled at edge E0. FRAME_START beat is valid after E1 when the stream FSM is idle.
- Frame length: 2 + `num_rows`·(`num_cols`+2) + (`num_rows`−1)·`row_blank` cycles. Pixels within a row are gapless.
- Back-to-back frames: at least 1 `dvo`=0 cycle (SIDLE) after FRAME_END.
- Reset or `enable` low mid-frame:
  - `dvo` drops immediately and no FRAME_END is emitted.
  - Both buffers are discarded.

## Configuration
- `DI2STREAM_FRAME_COUNT_EN` defined:
  - Adds output `frame_count` [15:0], reset 0. It increments at each FRAME_END and wraps 0xFFFF→0.
  - The FRAME_START beat carries `datao` = current `frame_count`.
- Undefined: the port is absent and FRAME_START `datao`=0.

## Test plan
- Basic frame: words 0x00020001, 0x00040003, 0x00060005, 0x00080007; `num_cols`=4, `num_rows`=2, `row_blank`=3 → FS, RS, 1, 2, 3, 4, RE, 3 idle cycles, RS, 5, 6, 7, 8, RE, FE; 17 cycles total.
- Odd width: words 0x00020001, 0x00040003, 0x00060005; `num_cols`=3, `num_rows`=2, `row_blank`=0 → rows 1,2,3 and 4,5,6; 12 cycles.
- Ping-pong: commit A, then commit B while A streams → B accepted (`di_write_rdy`=1). A third write session holds `di_write_rdy`=0 until A's FE, and B starts 1 idle cycle after A's FE.
- Empty commit: pulse `di_write_mode` with no `di_write` → no `dvo`, `full` stays 0.
- Zero dims: `num_rows`=0 → exactly FS then FE, buffer freed; a subsequent write is accepted.
- Mid-frame reset: assert `resetb`=0 during SPIX → `dvo`=0 asynchronously, all outputs at reset values. After release, no stream until a new commit. With `DI2STREAM_FRAME_COUNT_EN`, `frame_count`=0.

Source files
------------

// File: rtl/di2stream.sv
// di2stream: host-filled ping-pong frame buffer replayed as an image stream.
// Optional: define DI2STREAM_FRAME_COUNT_EN to add the frame_count output.
module di2stream #(
  parameter int ADDR_WIDTH    = 10,
  parameter int DI_DATA_WIDTH = 32,
  parameter int DIM_WIDTH     = 12,
  parameter int BLANK_WIDTH   = 8,
  parameter int DTYPE_WIDTH   = 3
) (
  input  logic                     clk,
  input  logic                     resetb,
  input  logic                     enable,
  input  logic [DIM_WIDTH-1:0]     num_cols,
  input  logic [DIM_WIDTH-1:0]     num_rows,
  input  logic [BLANK_WIDTH-1:0]   row_blank,
  input  logic                     di_write_mode,
  input  logic                     di_write,
  input  logic [DI_DATA_WIDTH-1:0] di_reg_datai,
  output logic                     di_write_rdy,
  output logic                     dvo,
  output logic [DTYPE_WIDTH-1:0]   dtypeo,
  output logic [15:0]              datao
`ifdef DI2STREAM_FRAME_COUNT_EN
  ,
  output logic [15:0]              frame_count
`endif
);

  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam logic [DTYPE_WIDTH-1:0] DT_FS  = DTYPE_WIDTH'(1);
  localparam logic [DTYPE_WIDTH-1:0] DT_RS  = DTYPE_WIDTH'(2);
  localparam logic [DTYPE_WIDTH-1:0] DT_PIX = DTYPE_WIDTH'(3);
  localparam logic [DTYPE_WIDTH-1:0] DT_RE  = DTYPE_WIDTH'(4);
  localparam logic [DTYPE_WIDTH-1:0] DT_FE  = DTYPE_WIDTH'(5);

  typedef enum logic {WIDLE, WRITING} wstate_e;
  typedef enum logic [2:0] {
    SIDLE, SFS, SRS, SPIX, SRE, SBLANK, SFE
  } sstate_e;

  logic [31:0] mem [2][DEPTH];

  wstate_e               wstate_q, wstate_d;
  logic [ADDR_WIDTH:0]   waddr_q, waddr_d;
  logic                  wbuf_q, wbuf_d;
  logic                  rbuf_q, rbuf_d;
  logic                  rdy_q, rdy_d;
  logic [1:0]            full_q, full_d;
  sstate_e               sstate_q, sstate_d;
  logic [ADDR_WIDTH:0]   p_q, p_d;
  logic [DIM_WIDTH-1:0]  col_q, col_d;
  logic [DIM_WIDTH-1:0]  row_q, row_d;
  logic [DIM_WIDTH-1:0]  cols_q, cols_d;
  logic [DIM_WIDTH-1:0]  rows_q, rows_d;
  logic [BLANK_WIDTH-1:0] bcnt_q, bcnt_d;
  logic [BLANK_WIDTH-1:0] blank_q, blank_d;
  logic                  dvo_q, dvo_d;
  logic [DTYPE_WIDTH-1:0] dtype_q, dtype_d;
  logic [15:0]           data_q, data_d;

  logic                  we, commit, rel;
  logic [31:0]           rword;
  logic [15:0]           pix, fs_data;
  logic [DIM_WIDTH-1:0]  row_inc;

  // Saturated address (MSB set) blocks further writes.
  assign we = enable && wstate_q == WRITING && di_write
              && !waddr_q[ADDR_WIDTH];
  assign rword = mem[rbuf_q][p_q[ADDR_WIDTH:1]];
  assign pix = p_q[0] ? rword[31:16] : rword[15:0];
  assign row_inc = row_q + 1'b1;

  always_ff @(posedge clk) begin
    if (we) mem[wbuf_q][waddr_q[ADDR_WIDTH-1:0]] <= di_reg_datai[31:0];
  end

`ifdef DI2STREAM_FRAME_COUNT_EN
  logic [15:0] fcnt_q, fcnt_d;

  always_comb begin
    fcnt_d = fcnt_q;
    if (sstate_q == SFE) fcnt_d = fcnt_q + 1'b1;
    if (!enable) fcnt_d = '0;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) fcnt_q <= '0;
    else fcnt_q <= fcnt_d;
  end

  assign fs_data = fcnt_q;
  assign frame_count = fcnt_q;
`else
  assign fs_data = '0;
`endif

  always_comb begin
    wstate_d = wstate_q;
    waddr_d = waddr_q;
    wbuf_d = wbuf_q;
    rdy_d = rdy_q;
    commit = 1'b0;
    unique case (wstate_q)
      WIDLE: begin
        waddr_d = '0;
        if (di_write_mode && !full_q[wbuf_q]) begin
          wstate_d = WRITING;
          rdy_d = 1'b1;
        end
      end
      WRITING: begin
        if (we) waddr_d = waddr_q + 1'b1;
        if (!di_write_mode) begin
          wstate_d = WIDLE;
          rdy_d = 1'b0;
          waddr_d = '0;
          if (waddr_q != '0 || we) begin
            commit = 1'b1;
            wbuf_d = ~wbuf_q;
          end
        end
      end
    endcase
  end

  always_comb begin
    sstate_d = sstate_q;
    rbuf_d = rbuf_q;
    p_d = p_q;
    col_d = col_q;
    row_d = row_q;
    bcnt_d = bcnt_q;
    cols_d = cols_q;
    rows_d = rows_q;
    blank_d = blank_q;
    dvo_d = 1'b0;
    dtype_d = '0;
    data_d = '0;
    rel = 1'b0;
    unique case (sstate_q)
      SIDLE: begin
        if (full_q[rbuf_q]) begin
          sstate_d = SFS;
          cols_d = num_cols;
          rows_d = num_rows;
          blank_d = row_blank;
          p_d = '0;
          row_d = '0;
          dvo_d = 1'b1;
          dtype_d = DT_FS;
          data_d = fs_data;
        end
      end
      SFS: begin
        dvo_d = 1'b1;
        if (cols_q == '0 || rows_q == '0) begin
          sstate_d = SFE;
          dtype_d = DT_FE;
        end else begin
          sstate_d = SRS;
          dtype_d = DT_RS;
        end
      end
      SRS: begin
        sstate_d = SPIX;
        col_d = DIM_WIDTH'(1);
        p_d = p_q + 1'b1;
        dvo_d = 1'b1;
        dtype_d = DT_PIX;
        data_d = pix;
      end
      SPIX: begin
        dvo_d = 1'b1;
        if (col_q == cols_q) begin
          sstate_d = SRE;
          dtype_d = DT_RE;
        end else begin
          col_d = col_q + 1'b1;
          p_d = p_q + 1'b1;
          dtype_d = DT_PIX;
          data_d = pix;
        end
      end
      SRE: begin
        row_d = row_inc;
        if (row_inc == rows_q) begin
          sstate_d = SFE;
          dvo_d = 1'b1;
          dtype_d = DT_FE;
        end else if (blank_q == '0) begin
          sstate_d = SRS;
          dvo_d = 1'b1;
          dtype_d = DT_RS;
        end else begin
          sstate_d = SBLANK;
          bcnt_d = BLANK_WIDTH'(1);
        end
      end
      SBLANK: begin
        if (bcnt_q == blank_q) begin
          sstate_d = SRS;
          dvo_d = 1'b1;
          dtype_d = DT_RS;
        end else begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      SFE: begin
        sstate_d = SIDLE;
        rel = 1'b1;
        rbuf_d = ~rbuf_q;
      end
      default: sstate_d = SIDLE;
    endcase
  end

  // Commit and release always target different buffers.
  always_comb begin
    full_d = full_q;
    if (rel) full_d[rbuf_q] = 1'b0;
    if (commit) full_d[wbuf_q] = 1'b1;
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb || !enable) begin
      wstate_q <= WIDLE;
      waddr_q  <= '0;
      wbuf_q   <= 1'b0;
      rbuf_q   <= 1'b0;
      rdy_q    <= 1'b0;
      full_q   <= '0;
      sstate_q <= SIDLE;
      p_q      <= '0;
      col_q    <= '0;
      row_q    <= '0;
      bcnt_q   <= '0;
      cols_q   <= '0;
      rows_q   <= '0;
      blank_q  <= '0;
      dvo_q    <= 1'b0;
      dtype_q  <= '0;
      data_q   <= '0;
    end else begin
      wstate_q <= wstate_d;
      waddr_q  <= waddr_d;
      wbuf_q   <= wbuf_d;
      rbuf_q   <= rbuf_d;
      rdy_q    <= rdy_d;
      full_q   <= full_d;
      sstate_q <= sstate_d;
      p_q      <= p_d;
      col_q    <= col_d;
      row_q    <= row_d;
      bcnt_q   <= bcnt_d;
      cols_q   <= cols_d;
      rows_q   <= rows_d;
      blank_q  <= blank_d;
      dvo_q    <= dvo_d;
      dtype_q  <= dtype_d;
      data_q   <= data_d;
    end
  end

  assign di_write_rdy = rdy_q;
  assign dvo = dvo_q;
  assign dtypeo = dtype_q;
  assign datao = data_q;

endmodule

// File: tb/tb_di2stream.sv
// tb_di2stream: directed frames checked beat by beat against
// hand-derived stream sequences.
module tb_di2stream;

  localparam logic [2:0] DT_FS  = 3'd1;
  localparam logic [2:0] DT_RS  = 3'd2;
  localparam logic [2:0] DT_PIX = 3'd3;
  localparam logic [2:0] DT_RE  = 3'd4;
  localparam logic [2:0] DT_FE  = 3'd5;

  logic        clk = 1'b0;
  logic        resetb, enable;
  logic [11:0] num_cols, num_rows;
  logic [7:0]  row_blank;
  logic        di_write_mode, di_write;
  logic [31:0] di_reg_datai;
  logic        di_write_rdy, dvo;
  logic [2:0]  dtypeo;
  logic [15:0] datao;
`ifdef DI2STREAM_FRAME_COUNT_EN
  logic [15:0] frame_count;
`endif

  int n_tests = 0;
  int n_fail = 0;
  int nfr = 0;
  logic [31:0] wdat [16];
  logic [15:0] pv [32];
  logic [19:0] expq [$];

  always #5 clk = ~clk;

  di2stream dut (
    .clk(clk),
    .resetb(resetb),
    .enable(enable),
    .num_cols(num_cols),
    .num_rows(num_rows),
    .row_blank(row_blank),
    .di_write_mode(di_write_mode),
    .di_write(di_write),
    .di_reg_datai(di_reg_datai),
    .di_write_rdy(di_write_rdy),
    .dvo(dvo),
    .dtypeo(dtypeo),
    .datao(datao)
`ifdef DI2STREAM_FRAME_COUNT_EN
    ,
    .frame_count(frame_count)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [19:0] enc(input logic v, input logic [2:0] t,
                                     input logic [15:0] d);
    return {v, t, d};
  endfunction

  task automatic cfg(input int c, input int r, input int b);
    num_cols = 12'(c);
    num_rows = 12'(r);
    row_blank = 8'(b);
  endtask

  // Words {2i+2, 2i+1}: pixels count up from 1.
  task automatic fill(input int n);
    for (int i = 0; i < n; i++) begin
      wdat[i] = {16'(2 * i + 2), 16'(2 * i + 1)};
      pv[2 * i] = 16'(2 * i + 1);
      pv[2 * i + 1] = 16'(2 * i + 2);
    end
  endtask

  task automatic write_buf(input int n);
    di_write_mode = 1'b1;
    for (int i = 0; i < 20 && !di_write_rdy; i++) @(negedge clk);
    check("rdy_wait", di_write_rdy, 1);
    for (int i = 0; i < n; i++) begin
      di_write = 1'b1;
      di_reg_datai = wdat[i];
      @(negedge clk);
    end
    di_write = 1'b0;
    di_write_mode = 1'b0;
  endtask

  task automatic build(input int c, input int r, input int b);
    int p = 0;
    logic [15:0] fsd = 16'd0;
`ifdef DI2STREAM_FRAME_COUNT_EN
    fsd = 16'(nfr);
`endif
    expq.delete();
    expq.push_back(enc(1'b1, DT_FS, fsd));
    if (c != 0 && r != 0) begin
      for (int row = 0; row < r; row++) begin
        expq.push_back(enc(1'b1, DT_RS, 16'd0));
        for (int col = 0; col < c; col++) begin
          expq.push_back(enc(1'b1, DT_PIX, pv[p]));
          p++;
        end
        expq.push_back(enc(1'b1, DT_RE, 16'd0));
        if (row < r - 1)
          for (int k = 0; k < b; k++) expq.push_back(20'd0);
      end
    end
    expq.push_back(enc(1'b1, DT_FE, 16'd0));
    nfr++;
  endtask

  task automatic expect_frame(input string tag, output int waited);
    logic [19:0] got, e;
    waited = 0;
    while (!dvo && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    check({tag, "_start"}, dvo, 1);
    if (!dvo) return;
    foreach (expq[i]) begin
      e = expq[i];
      got = {dvo, dtypeo, datao};
      if (!e[19]) got = {dvo, 19'd0};
      check(tag, got, e);
      @(negedge clk);
    end
    check({tag, "_end"}, dvo, 0);
  endtask

  task automatic wait_pix();
    for (int i = 0; i < 30 && !(dvo && dtypeo == DT_PIX); i++)
      @(negedge clk);
    check("pix_seen", dtypeo, DT_PIX);
  endtask

  task automatic count_dvo(input string tag, input int cyc);
    int cnt = 0;
    for (int i = 0; i < cyc; i++) begin
      @(negedge clk);
      if (dvo) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  int w;

  initial begin
    resetb = 1'b0;
    enable = 1'b1;
    di_write_mode = 1'b0;
    di_write = 1'b0;
    di_reg_datai = '0;
    cfg(0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_rdy", di_write_rdy, 0);
    check("rst_dvo", dvo, 0);
    check("rst_type", dtypeo, 0);
    check("rst_data", datao, 0);
`ifdef DI2STREAM_FRAME_COUNT_EN
    check("rst_fc", frame_count, 0);
`endif
    resetb = 1'b1;
    @(negedge clk);

    // Basic frame with row blanking.
    fill(4);
    cfg(4, 2, 3);
    write_buf(4);
    build(4, 2, 3);
    expect_frame("basic", w);
    check("basic_lat", w, 2);

    // Odd width: pixel index runs across rows.
    fill(3);
    cfg(3, 2, 0);
    write_buf(3);
    build(3, 2, 0);
    expect_frame("odd", w);
    check("odd_lat", w, 2);

    // Ping-pong: B written while A streams, third session held.
    fill(8);
    cfg(4, 4, 2);
    write_buf(8);
    build(4, 4, 2);
    fork
      begin
        int wa, wb;
        expect_frame("pp_a", wa);
        build(2, 2, 0);
        expect_frame("pp_b", wb);
        check("pp_gap", wb, 1);
      end
      begin
        repeat (2) @(negedge clk);
        cfg(2, 2, 0);
        wdat[0] = 32'h0012_0011;
        wdat[1] = 32'h0014_0013;
        pv[0] = 16'h0011;
        pv[1] = 16'h0012;
        pv[2] = 16'h0013;
        pv[3] = 16'h0014;
        write_buf(2);
        @(negedge clk);
        di_write_mode = 1'b1;
        repeat (3) @(negedge clk);
        check("pp_hold", di_write_rdy, 0);
      end
    join
    check("pp_rdy3", di_write_rdy, 1);

    // Session closed with no words: nothing committed.
    di_write_mode = 1'b0;
    count_dvo("empty", 10);

    // Zero rows: FS then FE, buffer handed back.
    fill(1);
    cfg(2, 0, 0);
    write_buf(1);
    build(2, 0, 0);
    expect_frame("zero", w);
    wdat[0] = 32'h00BB_00AA;
    pv[0] = 16'h00AA;
    pv[1] = 16'h00BB;
    cfg(2, 1, 0);
    write_buf(1);
    build(2, 1, 0);
    expect_frame("after0", w);

    // Enable low mid-frame discards everything.
    fill(4);
    cfg(4, 2, 0);
    write_buf(4);
    wait_pix();
    enable = 1'b0;
    @(negedge clk);
    check("en_dvo", dvo, 0);
    check("en_type", dtypeo, 0);
    enable = 1'b1;
    nfr = 0;
    count_dvo("en_discard", 12);

    // Asynchronous reset mid-frame.
    write_buf(4);
    wait_pix();
    #2 resetb = 1'b0;
    #1;
    check("arst_dvo", dvo, 0);
    check("arst_type", dtypeo, 0);
    check("arst_data", datao, 0);
    check("arst_rdy", di_write_rdy, 0);
`ifdef DI2STREAM_FRAME_COUNT_EN
    check("arst_fc", frame_count, 0);
`endif
    @(negedge clk);
    resetb = 1'b1;
    count_dvo("arst_discard", 12);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
